// File: rtl/vga_sync_decoder_pkg.sv
// Shared display timing for the 640x480 VGA receive path.
// Holds the nominal timing constants and the lock-state encoding.
package vga_sync_decoder_pkg;

    localparam int VGA_XBITS      = 10;
    localparam int VGA_YBITS      = 10;
    localparam int VGA_H_TOTAL    = 800;
    localparam int VGA_V_TOTAL    = 525;
    localparam int VGA_H_VISIBLE  = 640;
    localparam int VGA_V_VISIBLE  = 480;
    localparam int VGA_H_SYNC_END = 752;
    localparam int VGA_V_SYNC_END = 492;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_t;

endpackage

// File: rtl/vga_sync_decoder_meter.sv
// sync_period_meter: sync history flop, rise detect, saturating
// period counter and captured-period register.
// Ports:
//   clk, reset  clock, async active-high reset
//   pix_en      pixel strobe; all state moves only when high
//   sync_in     active-low sync being measured
//   cnt_en      event counted between rises (qualified by pix_en)
//   rise        combinational rise strobe (pix_en qualified)
//   cnt         events since the last rise, saturating
//   period      cnt (+1 if ADD_ONE) captured at each rise, saturating
module sync_period_meter
    import vga_sync_decoder_pkg::*;
#(
    parameter int CW      = 11,
    parameter int PW      = 10,
    parameter bit ADD_ONE = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          sync_in,
    input  logic          cnt_en,
    output logic          rise,
    output logic [CW-1:0] cnt,
    output logic [PW-1:0] period
);

    logic          sync_q;
    logic [CW:0]   cap_full;
    logic [CW:0]   pmax;

    // History resets high so a reset inside a pulse cannot fake a rise.
    assign rise     = pix_en && sync_in && !sync_q;
    assign pmax     = {{(CW + 1 - PW){1'b0}}, {PW{1'b1}}};
    assign cap_full = {1'b0, cnt} + {{CW{1'b0}}, ADD_ONE};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b1;
            cnt    <= '0;
            period <= '0;
        end else if (pix_en) begin
            sync_q <= sync_in;
            if (rise) begin
                cnt    <= '0;
                period <= (cap_full > pmax) ? pmax[PW-1:0]
                                            : cap_full[PW-1:0];
            end else if (cnt_en && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive side of the VGA timing link: recovers x/y/activevideo
// from hsync/vsync, measures line and frame length, tracks lock.
// Ports:
//   clk, reset         clock, async active-high reset
//   pix_en             pixel strobe gating all sampling/counting
//   hsync_in/vsync_in  active-low syncs
//   x, y, activevideo  recovered position, one pix_en behind source
//   locked, lock_lost  lock state and one-clk loss pulse
//   line_len           last pixels per line (rise to rise)
//   frame_lines        last lines per frame (rise to rise)
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int XBITS      = VGA_XBITS,
    parameter int YBITS      = VGA_YBITS,
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_TOTAL    = VGA_V_TOTAL,
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int H_SYNC_END = VGA_H_SYNC_END,
    parameter int V_SYNC_END = VGA_V_SYNC_END
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             activevideo,
    output logic             locked,
    output logic             lock_lost,
    output logic [XBITS-1:0] line_len,
    output logic [YBITS-1:0] frame_lines
);

    // One extra bit so the line counter can reach the 2-line timeout.
    localparam int HCW = XBITS + 1;

    localparam logic [HCW-1:0]   H_LEN_M1 = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0]   TMO_M1   = HCW'(2 * H_TOTAL - 1);
    localparam logic [XBITS-1:0] X_LAST   = XBITS'(H_TOTAL - 1);
    localparam logic [XBITS-1:0] X_SYNC   = XBITS'(H_SYNC_END);
    localparam logic [XBITS-1:0] X_VIS    = XBITS'(H_VISIBLE);
    localparam logic [YBITS-1:0] Y_LAST   = YBITS'(V_TOTAL - 1);
    localparam logic [YBITS-1:0] Y_SYNC   = YBITS'(V_SYNC_END);
    localparam logic [YBITS-1:0] Y_VIS    = YBITS'(V_VISIBLE);
    localparam logic [YBITS-1:0] V_TOT_C  = YBITS'(V_TOTAL);

    logic             h_rise;
    logic             v_rise;
    logic [HCW-1:0]   hcnt;
    logic [YBITS-1:0] vcnt;

    sync_state_t state;
    sync_state_t state_n;
    logic        bad;
    logic        bad_n;
    logic        primed;
    logic        primed_n;
    logic        lost_n;
    logic        h_bad;
    logic        v_ok;
    logic        timeout;
    logic        x_wrap;

    sync_period_meter #(
        .CW      (HCW),
        .PW      (XBITS),
        .ADD_ONE (1'b1)
    ) u_hmeter (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .sync_in (hsync_in),
        .cnt_en  (1'b1),
        .rise    (h_rise),
        .cnt     (hcnt),
        .period  (line_len)
    );

    sync_period_meter #(
        .CW      (YBITS),
        .PW      (YBITS),
        .ADD_ONE (1'b0)
    ) u_vmeter (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .sync_in (vsync_in),
        .cnt_en  (h_rise),
        .rise    (v_rise),
        .cnt     (vcnt),
        .period  (frame_lines)
    );

    // Length checks look at the value being captured on this edge,
    // so a bad line drops lock at the very rise that measured it.
    // primed masks the partial first line seen after SEARCH.
    assign h_bad   = h_rise && primed && (hcnt != H_LEN_M1);
    assign v_ok    = (vcnt == V_TOT_C);
    assign timeout = pix_en && !h_rise && (hcnt >= TMO_M1);
    assign x_wrap  = (x == X_LAST);

    always_comb begin
        state_n  = state;
        bad_n    = bad;
        primed_n = primed;
        lost_n   = 1'b0;
        if (pix_en) begin
            if (h_rise)
                primed_n = 1'b1;
            if (timeout) begin
                state_n  = ST_SEARCH;
                primed_n = 1'b0;
                lost_n   = (state == ST_LOCKED);
            end else begin
                unique case (state)
                    ST_SEARCH: begin
                        if (v_rise) begin
                            state_n = ST_ACQUIRE;
                            bad_n   = 1'b0;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (v_rise) begin
                            if (v_ok && !bad && !h_bad)
                                state_n = ST_LOCKED;
                            else
                                bad_n = 1'b0;
                        end else if (h_bad) begin
                            bad_n = 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (h_bad || (v_rise && !v_ok)) begin
                            state_n  = ST_SEARCH;
                            primed_n = 1'b0;
                            lost_n   = 1'b1;
                        end
                    end
                    default: state_n = ST_SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SEARCH;
            bad       <= 1'b0;
            primed    <= 1'b0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_lost <= lost_n;
            if (pix_en) begin
                state  <= state_n;
                bad    <= bad_n;
                primed <= primed_n;
                locked <= (state_n == ST_LOCKED);
            end
        end
    end

    // A v-rise wins over the line-wrap increment of y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (pix_en) begin
            if (h_rise)
                x <= X_SYNC;
            else if (x_wrap)
                x <= '0;
            else
                x <= x + 1'b1;

            if (v_rise)
                y <= Y_SYNC;
            else if (x_wrap && !h_rise)
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    assign activevideo = locked && (x < X_VIS) && (y < Y_VIS);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (20x12).
// Scoreboard of generator coordinates vs recovered x/y/activevideo.
module tb_vga_sync_decoder;

    localparam int HT  = 20;
    localparam int HV  = 16;
    localparam int HSS = 17;
    localparam int HSE = 19;
    localparam int VT  = 12;
    localparam int VV  = 8;
    localparam int VSS = 9;
    localparam int VSE = 10;

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       activevideo;
    logic       locked;
    logic       lock_lost;
    logic [9:0] line_len;
    logic [9:0] frame_lines;

    typedef struct {
        int ex;
        int ey;
        int eav;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int lost_cnt = 0;
    int vrise_cnt = 0;
    int gx, gy, extra, skip;
    int pres_x, pres_y;
    bit hold, track, vrise_now;
    bit locked_pre, locked_a, lost_a, lost_b, av_a;
    int lc0, k;
    bit done;

    vga_sync_decoder #(
        .XBITS      (10),
        .YBITS      (10),
        .H_TOTAL    (HT),
        .V_TOTAL    (VT),
        .H_VISIBLE  (HV),
        .V_VISIBLE  (VV),
        .H_SYNC_END (HSE),
        .V_SYNC_END (VSE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .x           (x),
        .y           (y),
        .activevideo (activevideo),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .line_len    (line_len),
        .frame_lines (frame_lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic advance();
        if (gx == HT - 1) begin
            if (extra > 0) begin
                extra--;
            end else begin
                gx = 0;
                if (gy == VT - 2 && skip > 0) begin
                    skip--;
                    gy = 0;
                end else if (gy == VT - 1) begin
                    gy = 0;
                end else begin
                    gy++;
                end
            end
        end else begin
            gx++;
        end
    endtask

    // One pixel period: 4 clks, pix_en high across one posedge.
    task automatic tick_pix();
        exp_t e;
        @(negedge clk);
        hsync_in  = hold ? 1'b1 : !(gx >= HSS && gx < HSE);
        vsync_in  = !(gy >= VSS && gy < VSE);
        vrise_now = (gx == 0 && gy == VSE);
        pres_x    = gx;
        pres_y    = gy;
        if (track) begin
            e.ex  = gx;
            e.ey  = gy;
            e.eav = (gx < HV && gy < VV) ? 1 : 0;
            sb_q.push_back(e);
        end
        locked_pre = locked;
        pix_en     = 1'b1;
        @(negedge clk);
        pix_en   = 1'b0;
        locked_a = locked;
        lost_a   = lock_lost;
        av_a     = activevideo;
        if (vrise_now)
            vrise_cnt++;
        advance();
        @(negedge clk);
        lost_b = lock_lost;
        @(negedge clk);
    endtask

    task automatic run_until(input int tx, input int ty);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick_pix();
            if (pres_x == tx && pres_y == ty)
                hit = 1'b1;
        end
        chk("run_until_reached", int'(hit), 1);
    endtask

    task automatic wait_vrise();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick_pix();
            if (vrise_now)
                hit = 1'b1;
        end
        chk("vrise_reached", int'(hit), 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (lock_lost === 1'b1)
                lost_cnt++;
        end
    end

    // Monitor: each pix_en edge with pending expectations is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (pix_en && sb_q.size() > 0) begin
                #1;
                e = sb_q.pop_front();
                chk("sb_x", int'(x), e.ex);
                chk("sb_y", int'(y), e.ey);
                chk("sb_activevideo", int'(activevideo), e.eav);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        pix_en = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        gx = 0; gy = 0; extra = 0; skip = 0;
        hold = 1'b0; track = 1'b0;

        // 1: reset with idle syncs
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_av", int'(activevideo), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_lost", int'(lock_lost), 0);
        chk("rst_line_len", int'(line_len), 0);
        chk("rst_frame_lines", int'(frame_lines), 0);
        reset = 1'b0;
        tick_pix();
        chk("rel_x_no_false_hrise", int'(x), 1);
        chk("rel_y_no_false_vrise", int'(y), 0);
        chk("rel_line_len", int'(line_len), 0);
        chk("rel_lost_cnt", lost_cnt, 0);

        // 2: lock on the second v-rise, then score frame 3
        wait_vrise();
        chk("vrise1_locked", int'(locked_a), 0);
        wait_vrise();
        chk("vrise2_locked_before", int'(locked_pre), 0);
        chk("vrise2_locked_after", int'(locked_a), 1);
        run_until(HT - 1, VT - 1);
        track = 1'b1;
        repeat (HT * VT) tick_pix();
        track = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("nom_line_len", int'(line_len), HT);
        chk("nom_frame_lines", int'(frame_lines), VT);
        chk("nom_locked", int'(locked), 1);

        // 3: one line stretched by a pixel
        lc0 = lost_cnt;
        run_until(HT - 1, 4);
        extra = 1;
        run_until(HSE, 6);
        chk("stretch_lost_pulse", int'(lost_a), 1);
        chk("stretch_lost_clear", int'(lost_b), 0);
        chk("stretch_locked", int'(locked_a), 0);
        chk("stretch_line_len", int'(line_len), HT + 1);
        run_until(5, 7);
        chk("stretch_av_off", int'(av_a), 0);
        chk("stretch_x_realign", int'(x), 5);
        wait_vrise();
        chk("relock_vrise1", int'(locked_a), 0);
        wait_vrise();
        chk("relock_vrise2", int'(locked_a), 1);
        chk("stretch_lost_count", lost_cnt - lc0, 1);

        // 4: hsync held high -> timeout after 2 lines of pixels
        run_until(HSE, 2);
        hold = 1'b1;
        lc0 = lost_cnt;
        k = 0;
        done = 1'b0;
        for (int i = 1; i <= 100 && !done; i++) begin
            tick_pix();
            if (!locked_a) begin
                k = i;
                done = 1'b1;
            end
        end
        chk("timeout_pix", k, 2 * HT);
        chk("timeout_lost_count", lost_cnt - lc0, 1);
        hold = 1'b0;

        // 5: short frame while acquiring
        reset = 1'b1;
        repeat (2) @(negedge clk);
        gx = 0; gy = 0; skip = 1;
        reset = 1'b0;
        wait_vrise();
        chk("short_vrise1_locked", int'(locked_a), 0);
        wait_vrise();
        chk("short_frame_lines", int'(frame_lines), VT - 1);
        chk("short_locked", int'(locked_a), 0);
        wait_vrise();
        chk("good_frame_lines", int'(frame_lines), VT);
        chk("good_locked", int'(locked_a), 1);

        // 6: async reset mid-frame, released inside an hsync pulse
        lc0 = lost_cnt;
        run_until(5, 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_x", int'(x), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_av", int'(activevideo), 0);
        chk("arst_line_len", int'(line_len), 0);
        chk("arst_frame_lines", int'(frame_lines), 0);
        run_until(HSS, 3);
        reset = 1'b0;
        tick_pix();
        chk("arst_rel_x", int'(x), 1);
        chk("arst_rel_line_len", int'(line_len), 0);
        chk("arst_rel_locked", int'(locked_a), 0);
        tick_pix();
        chk("arst_hrise_x", int'(x), HSE);
        chk("arst_partial_len", int'(line_len), 2);
        chk("arst_lost_count", lost_cnt - lc0, 0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
